// File: rtl/fifo_rd_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arb_if
// Purpose  : Bundle of FIFO read-side and arbitrated-output signals for fifo_rd_arb.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_rd_arb_if #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]  req;
  logic             rempty;
  logic [DSIZE-1:0] rdata;
  logic             rinc;
  logic [NREQ-1:0]  gnt;
  logic [DSIZE-1:0] dout;
  logic             dout_valid;
  logic [1:0]       dout_id;
  logic             busy;

  // Arbiter side
  modport master (
    input  req, rempty, rdata,
    output rinc, gnt, dout, dout_valid, dout_id, busy
  );

  // FIFO / requester side
  modport slave (
    output req, rempty, rdata,
    input  rinc, gnt, dout, dout_valid, dout_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_arb
// Purpose  : Round-robin burst arbiter granting FIFO read access to 4 requesters.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_arb #(
  parameter int DSIZE = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  wire logic    rclk,
  input  wire logic    rrst,
  fifo_rd_arb_if.master bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] C_BURST_LAST = 4'(BURST - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [3:0]       r_count;
  logic [NREQ-1:0]  r_gnt;
  logic [DSIZE-1:0] r_dout;
  logic             r_dout_valid;
  logic [1:0]       r_dout_id;

  logic [1:0]       w_winner;
  logic [1:0]       w_idx;
  logic             w_found;
  logic             w_rinc;
  logic             w_done;

  // Round-robin search starting one past the previous winner; i==4 wraps onto r_last itself.
  always_comb begin
    w_winner = r_last;
    w_idx    = '0;
    w_found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      w_idx = r_last + 2'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rinc      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && !bus.rempty) begin
          w_state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Reset gates the read strobe so an aborted burst never pops the FIFO.
        w_rinc = bus.req[r_owner] && !bus.rempty && !rrst;
        w_done = !bus.req[r_owner] || bus.rempty ||
                 (w_rinc && (r_count == C_BURST_LAST));
        if (w_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_owner      <= 2'd0;
      r_last       <= 2'd3;
      r_count      <= 4'd0;
      r_gnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_id    <= 2'd0;
    end else begin
      if (r_state == ST_IDLE && w_state_nxt == ST_GRANT) begin
        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
        r_owner <= w_winner;
        r_last  <= w_winner;
        r_count <= 4'd0;
      end else if (r_state == ST_GRANT && w_state_nxt == ST_IDLE) begin
        r_gnt <= '0;
      end
      if (w_rinc) begin
        r_count <= r_count + 4'd1;
      end
      r_dout_valid <= w_rinc;
      if (w_rinc) begin
        r_dout    <= bus.rdata;
        r_dout_id <= r_owner;
      end
    end
  end

  assign bus.rinc       = w_rinc;
  assign bus.gnt        = r_gnt;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.dout_id    = r_dout_id;
  assign bus.busy       = (r_state == ST_GRANT);

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_arb
// Purpose  : Self-checking bench for fifo_rd_arb with FIFO model and read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_arb;
  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_arb_if #(.DSIZE(DSIZE), .NREQ(NREQ)) bus ();

  fifo_rd_arb #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
    .rclk (clk),
    .rrst (rst),
    .bus  (bus)
  );

  // FIFO storage driven by the bench; rdata shows the word at the read pointer.
  logic [7:0] mem [0:65535];
  int         rptr = 0;
  int         wptr = 0;
  logic       stall = 1'b0;
  logic [3:0] req_drv = 4'b0;

  assign bus.req    = req_drv;
  assign bus.rempty = (rptr == wptr) || stall;
  assign bus.rdata  = mem[rptr[15:0]];

  // Reference model state, representing the DUT registers after the last posedge.
  bit         m_state = 1'b0;
  logic [3:0] m_gnt   = 4'b0;
  logic [1:0] m_owner = 2'd0;
  logic [1:0] m_last  = 2'd3;
  int         m_count = 0;
  logic [7:0] m_dout  = 8'd0;
  logic       m_dv    = 1'b0;
  logic [1:0] m_did   = 2'd0;
  bit         pend_rinc = 1'b0;

  logic [9:0] exp_q [$];
  int         gnt_log [$];
  logic [3:0] prev_gnt = 4'b0;
  int         n_checks = 0;
  int         n_errs   = 0;
  int         n_rinc   = 0;
  int         n_dv     = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_log(input string tag, input int n, input int e [5]);
    for (int k = 0; k < n; k++) begin
      chk(tag, (k < gnt_log.size()) ? gnt_log[k] : 99, e[k]);
    end
  endtask

  // One clock cycle: apply stimulus at negedge, check, then advance the model.
  task automatic cycle(input logic [3:0] r, input logic s, input logic rs, input int nwr);
    logic       m_rinc;
    logic [9:0] e;
    logic       done;
    int         w;
    int         idx;
    bit         found;
    @(negedge clk);
    if (pend_rinc) rptr++;
    for (int k = 0; k < nwr; k++) begin
      mem[wptr[15:0]] = 8'($urandom);
      wptr++;
    end
    req_drv = r;
    stall   = s;
    rst     = rs;
    #1;
    chk("gnt", bus.gnt, m_gnt);
    chk("gnt_onehot", ($countones(bus.gnt) <= 1), 1);
    chk("busy", bus.busy, m_state);
    chk("dout_valid", bus.dout_valid, m_dv);
    chk("dout_id", bus.dout_id, m_did);
    chk("dout", bus.dout, m_dout);
    idx = 0;
    for (int k = 0; k < 4; k++) if (bus.gnt[k]) idx = k;
    if (bus.gnt != 4'b0 && prev_gnt == 4'b0) gnt_log.push_back(idx);
    prev_gnt = bus.gnt;
    if (bus.dout_valid) begin
      n_dv++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", bus.dout, e[7:0]);
        chk("sb_id", bus.dout_id, e[9:8]);
      end
    end
    m_rinc = !rs && m_state && r[m_owner] && !bus.rempty;
    chk("rinc", bus.rinc, m_rinc);
    chk("rinc_while_empty", bus.rinc & bus.rempty, 0);
    if (rs) chk("rinc_in_reset", bus.rinc, 0);
    if (bus.rinc) n_rinc++;
    if (m_rinc) exp_q.push_back({m_owner, bus.rdata});
    pend_rinc = m_rinc;
    if (rs) begin
      m_state = 1'b0; m_gnt = 4'b0; m_owner = 2'd0; m_last = 2'd3; m_count = 0;
      m_dout = 8'd0; m_dv = 1'b0; m_did = 2'd0;
      exp_q.delete();
    end else begin
      m_dv = m_rinc;
      if (m_rinc) begin
        m_dout = bus.rdata;
        m_did  = m_owner;
      end
      if (!m_state) begin
        if (|r && !bus.rempty) begin
          found = 1'b0;
          w = 0;
          for (int i = 1; i <= 4; i++) begin
            if (!found && r[(m_last + i) % 4]) begin
              found = 1'b1;
              w = (m_last + i) % 4;
            end
          end
          m_state = 1'b1; m_gnt = 4'b1 << w; m_owner = 2'(w); m_last = 2'(w); m_count = 0;
        end
      end else begin
        done = !r[m_owner] || bus.rempty || (m_rinc && m_count == BURST - 1);
        if (m_rinc) m_count++;
        if (done) begin
          m_state = 1'b0;
          m_gnt   = 4'b0;
        end
      end
    end
  endtask

  // Quiesce, reset for two cycles, drain the FIFO, then check reset values.
  task automatic reset_all();
    cycle(4'b0, 1'b0, 1'b0, 0);
    cycle(4'b0, 1'b0, 1'b0, 0);
    cycle(4'b0, 1'b0, 1'b1, 0);
    cycle(4'b0, 1'b0, 1'b1, 0);
    rptr = wptr;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_dout_id", bus.dout_id, 0);
    gnt_log.delete();
  endtask

  initial begin
    // Single requester, ten words: two full bursts separated by one idle cycle.
    reset_all();
    cycle(4'b0001, 1'b0, 1'b0, 10);
    for (int c = 0; c < 12; c++) cycle(4'b0001, 1'b0, 1'b0, 0);
    chk_log("single_regrant", 2, '{0, 0, 0, 0, 0});

    // All requesting with a deep FIFO: strict rotation 0,1,2,3,0.
    reset_all();
    cycle(4'b1111, 1'b0, 1'b0, 60);
    for (int c = 0; c < 25; c++) cycle(4'b1111, 1'b0, 1'b0, 0);
    chk_log("rr_order", 5, '{0, 1, 2, 3, 0});

    // Two words only: burst cut short by empty, stays idle until refilled.
    reset_all();
    cycle(4'b0010, 1'b0, 1'b0, 2);
    for (int c = 0; c < 7; c++) cycle(4'b0010, 1'b0, 1'b0, 0);
    chk("empty_idle_busy", bus.busy, 0);
    chk("empty_idle_gnt", bus.gnt, 0);
    cycle(4'b0010, 1'b0, 1'b0, 3);
    for (int c = 0; c < 5; c++) cycle(4'b0010, 1'b0, 1'b0, 0);
    chk_log("empty_regrant", 2, '{1, 1, 0, 0, 0});

    // Owner 2 drops after one word: next grant goes to 3.
    reset_all();
    cycle(4'b0100, 1'b0, 1'b0, 20);
    cycle(4'b0100, 1'b0, 1'b0, 0);
    for (int c = 0; c < 6; c++) cycle(4'b1001, 1'b0, 1'b0, 0);
    chk_log("drop_to3", 2, '{2, 3, 0, 0, 0});

    // Owner 2 drops with only requester 0 left: search wraps to 0.
    reset_all();
    cycle(4'b0100, 1'b0, 1'b0, 20);
    cycle(4'b0100, 1'b0, 1'b0, 0);
    for (int c = 0; c < 6; c++) cycle(4'b0001, 1'b0, 1'b0, 0);
    chk_log("drop_wrap0", 2, '{2, 0, 0, 0, 0});

    // Reset mid-burst after two reads: aborted, then requester 0 first again.
    reset_all();
    cycle(4'b1111, 1'b0, 1'b0, 20);
    cycle(4'b1111, 1'b0, 1'b0, 0);
    cycle(4'b1111, 1'b0, 1'b0, 0);
    cycle(4'b1111, 1'b0, 1'b1, 0);
    cycle(4'b1111, 1'b0, 1'b0, 0);
    chk("midrst_gnt", bus.gnt, 0);
    chk("midrst_dout_valid", bus.dout_valid, 0);
    chk("midrst_busy", bus.busy, 0);
    for (int c = 0; c < 4; c++) cycle(4'b1111, 1'b0, 1'b0, 0);
    chk_log("midrst_order", 2, '{0, 0, 0, 0, 0});

    // Randomised requests, empty stalls and refill rate.
    reset_all();
    for (int c = 0; c < 10000; c++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
            1'b0, ((wptr - rptr) < 8) ? int'($urandom_range(0, 2)) : 0);
    end
    cycle(4'b0, 1'b0, 1'b0, 0);
    cycle(4'b0, 1'b0, 1'b0, 0);
    cycle(4'b0, 1'b0, 1'b0, 0);

    chk("rinc_vs_dv_count", n_rinc, n_dv);
    chk("sb_leftover", exp_q.size(), 0);
    chk("rd_activity", (n_rinc > 1000), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
`default_nettype wire
